// File: rtl/hamming_decoder_pipe.sv
// Hamming(15,11) receive-side decoder.
// Stage 1 captures the codeword and its syndrome; stage 2 flips the indicated
// bit and extracts the 11 data bits. Valid/ready on both sides, with
// saturating word and correction counters counted at the output handshake.
module hamming_decoder_pipe #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [14:0]          in_code,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [10:0]          out_data,
  output logic                 err_corr,
  output logic [3:0]           err_pos,
  input  logic                 clr_cnt,
  output logic [CNT_WIDTH-1:0] word_cnt,
  output logic [CNT_WIDTH-1:0] corr_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic        s1_valid;
  logic [14:0] s1_code;
  logic [3:0]  s1_syn;

  logic        s1_adv;
  logic        s2_adv;
  logic        in_hs;
  logic        out_hs;
  logic [3:0]  syn;
  logic [15:0] flip_mask;
  logic [14:0] fixed_code;
  logic [10:0] fixed_data;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;

  // Each syndrome bit checks the positions (k+1) that have that bit set.
  assign syn[0] = ^(in_code & 15'h5555);
  assign syn[1] = ^(in_code & 15'h6666);
  assign syn[2] = ^(in_code & 15'h7878);
  assign syn[3] = ^(in_code & 15'h7F80);

  // A zero syndrome lands the one-hot bit on mask[0], which is dropped below,
  // so no separate "no error" path is needed.
  assign flip_mask  = 16'd1 << s1_syn;
  assign fixed_code = s1_code ^ flip_mask[15:1];
  assign fixed_data = {fixed_code[2],  fixed_code[4],  fixed_code[5],  fixed_code[6],
                       fixed_code[8],  fixed_code[9],  fixed_code[10], fixed_code[11],
                       fixed_code[12], fixed_code[13], fixed_code[14]};

  // Stage 1: capture codeword and syndrome on the input handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_syn   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_code <= in_code;
        s1_syn  <= syn;
      end
    end
  end

  // Stage 2: corrected data and error report, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      err_corr  <= 1'b0;
      err_pos   <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= fixed_data;
        err_corr <= (s1_syn != 4'd0);
        err_pos  <= s1_syn;
      end
    end
  end

  // Link statistics: saturating, clear wins over a same-cycle delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
      corr_cnt <= '0;
    end else if (clr_cnt) begin
      word_cnt <= '0;
      corr_cnt <= '0;
    end else if (out_hs) begin
      if (word_cnt != CNT_MAX) word_cnt <= word_cnt + 1'b1;
      if (err_corr && (corr_cnt != CNT_MAX)) corr_cnt <= corr_cnt + 1'b1;
    end
  end

  logic unused_in_hs;
  assign unused_in_hs = in_hs;

endmodule

// File: tb/tb_hamming_decoder_pipe.sv
// Self-checking bench for hamming_decoder_pipe: a queue-based reference model
// scored on every falling edge, plus directed literal checks.
module tb_hamming_decoder_pipe;

  localparam int CW     = 4;
  localparam int CMAX   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [14:0]   in_code;
  logic          out_valid;
  logic          out_ready;
  logic [10:0]   out_data;
  logic          err_corr;
  logic [3:0]    err_pos;
  logic          clr_cnt;
  logic [CW-1:0] word_cnt;
  logic [CW-1:0] corr_cnt;

  hamming_decoder_pipe #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .err_corr(err_corr), .err_pos(err_pos),
    .clr_cnt(clr_cnt), .word_cnt(word_cnt), .corr_cnt(corr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] d;
    logic        c;
    logic [3:0]  p;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];
  int   m_word  = 0;
  int   m_corr  = 0;
  logic prev_stall = 1'b0;
  exp_t prev_pay;
  logic bp_mode = 1'b0;
  logic or_hold = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_pow2(input int pos);
    return (pos & (pos - 1)) == 0;
  endfunction

  // Data v10..v0 fill the non-power-of-two positions in ascending order;
  // each parity position makes its group's XOR zero.
  function automatic logic [14:0] enc(input logic [10:0] v);
    logic [14:0] c = '0;
    int j = 10;
    for (int pos = 1; pos <= 15; pos++)
      if (!is_pow2(pos)) begin c[pos-1] = v[j]; j--; end
    for (int i = 0; i < 4; i++) begin
      logic p = 1'b0;
      for (int pos = 1; pos <= 15; pos++)
        if (((pos >> i) & 1) == 1 && !is_pow2(pos)) p ^= c[pos-1];
      c[(1 << i) - 1] = p;
    end
    return c;
  endfunction

  function automatic exp_t dec(input logic [14:0] code);
    exp_t r;
    int s = 0;
    int j = 10;
    logic [14:0] c = code;
    for (int i = 0; i < 4; i++) begin
      logic b = 1'b0;
      for (int pos = 1; pos <= 15; pos++)
        if (((pos >> i) & 1) == 1) b ^= c[pos-1];
      if (b) s += (1 << i);
    end
    if (s != 0) c[s-1] = ~c[s-1];
    r.d = '0;
    for (int pos = 1; pos <= 15; pos++)
      if (!is_pow2(pos)) begin r.d[j] = c[pos-1]; j--; end
    r.c = (s != 0);
    r.p = 4'(s);
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    out_ready = bp_mode ? 1'($urandom_range(0, 1)) : or_hold;
  end

  // Scoreboard and per-cycle protocol checks.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_word = 0;
      m_corr = 0;
      prev_stall = 1'b0;
    end else begin
      exp_t e;
      chk("in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
      if (q.size() == 0) chk("no_phantom_valid", 32'(out_valid), 32'd0);
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_payload", 32'({out_data, err_corr, err_pos}), 32'(prev_pay));
      end
      chk("word_cnt", 32'(word_cnt), 32'(m_word));
      chk("corr_cnt", 32'(corr_cnt), 32'(m_corr));
      if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("out_data", 32'(out_data), 32'(e.d));
        chk("err_corr", 32'(err_corr), 32'(e.c));
        chk("err_pos",  32'(err_pos),  32'(e.p));
      end
      if (clr_cnt) begin
        m_word = 0;
        m_corr = 0;
      end else if (out_valid && out_ready) begin
        if (m_word < CMAX) m_word++;
        if (err_corr && m_corr < CMAX) m_corr++;
      end
      prev_stall = out_valid && !out_ready;
      prev_pay   = '{out_data, err_corr, err_pos};
      if (in_valid && in_ready) q.push_back(dec(in_code));
    end
  end

  // Presents one word and returns just after the edge that accepts it.
  task automatic send(input logic [14:0] code);
    int n = 0;
    in_valid = 1'b1;
    in_code  = code;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        chk("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    logic [10:0] d;
    logic [14:0] c;
    logic [14:0] one;

    rst_n = 1'b0; in_valid = 1'b0; in_code = '0; clr_cnt = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_word_cnt",  32'(word_cnt),  32'd0);

    // Pin the reference model with hand-derived values.
    chk("model_enc_400", 32'(enc(11'h400)), 32'h0007);
    chk("model_enc_7ff", 32'(enc(11'h7FF)), 32'h7FFF);
    e = dec(15'h0207);
    chk("model_dec_0207", 32'(e), 32'({11'h400, 1'b1, 4'hA}));
    e = dec(15'h0087);
    chk("model_dec_0087", 32'(e), 32'({11'h400, 1'b1, 4'h8}));

    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean words with literal two-cycle latency.
    send(15'h0007);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_not_yet", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_data",  32'(out_data),  32'h400);
    chk("lat_corr",  32'(err_corr),  32'd0);
    chk("lat_pos",   32'(err_pos),   32'd0);
    send(15'h0000);
    send(15'h7FFF);
    send(15'h0207);
    send(15'h0087);
    send(15'h0007 ^ 15'h0003);
    drain();

    // Every single flip of a few random codewords.
    for (int w = 0; w < 4; w++) begin
      d = 11'($urandom);
      c = enc(d);
      for (int b = 0; b < 15; b++) begin
        one = 15'd1 << b;
        e = dec(c ^ one);
        chk("model_restore", 32'(e.d), 32'(d));
        send(c ^ one);
      end
    end
    drain();

    // Random backpressure on a back-to-back stream.
    bp_mode = 1'b1;
    for (int k = 0; k < 8; k++) begin
      c = enc(11'($urandom));
      if (k % 3 == 1) c[k] = ~c[k];
      send(c);
    end
    drain();
    bp_mode = 1'b0;

    // Asynchronous reset with both stages full.
    or_hold = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    send(enc(11'h155));
    send(enc(11'h2AA));
    in_valid = 1'b0;
    #1;
    chk("full_valid",    32'(out_valid), 32'd1);
    chk("full_in_ready", 32'(in_ready),  32'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_word_cnt",  32'(word_cnt),  32'd0);
    chk("arst_corr_cnt",  32'(corr_cnt),  32'd0);
    chk("arst_in_ready",  32'(in_ready),  32'd1);
    or_hold = 1'b1;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(15'h0207);
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_not_yet", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_data",  32'(out_data),  32'h400);
    chk("post_rst_pos",   32'(err_pos),   32'hA);
    drain();

    // Saturating counters and clear priority.
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    for (int k = 0; k < 20; k++) begin
      c = enc(11'($urandom));
      if (k == 2 || k == 9 || k == 17) c[k % 15] = ~c[k % 15];
      send(c);
    end
    drain();
    chk("sat_word_cnt", 32'(word_cnt), 32'd15);
    chk("sat_corr_cnt", 32'(corr_cnt), 32'd3);
    send(enc(11'h123));
    in_valid = 1'b0;
    @(posedge clk); #1;
    clr_cnt = 1'b1;
    @(negedge clk);
    chk("clr_hs_active", 32'(out_valid && out_ready), 32'd1);
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    @(negedge clk);
    chk("clr_word_cnt", 32'(word_cnt), 32'd0);
    chk("clr_corr_cnt", 32'(corr_cnt), 32'd0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
